sr_pulse_driver: RTL

Synchronous front-end stage that drives the enable/set/reset inputs (e, s, r) of the gated SR latch from clocked set/clear requests. It sequences each command as setup → enable pulse → hold, so s/r are always stable around the enable window and s and r are never high together. With the verify option compiled in, it reads back the latch outputs (q, qnot) and reports a mismatch.

---
 rtl/sr_pulse_driver.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sr_pulse_driver.sv
// Clocked sequencer for a gated SR latch: setup -> enable pulse -> hold per set/clear command.
// Define SR_PULSE_DRIVER_VERIFY_EN to add a CHECK state that reads back q/qnot and flags err.
module sr_pulse_driver #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q,
    input  logic qnot,
    output logic e,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic conflict,
    output logic err
);

`ifdef SR_PULSE_DRIVER_VERIFY_EN
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD} state_t;
`endif

    // Counters hold "cycles remaining minus one" so a phase ends when they reach zero.
    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYC - 1);

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       cmd_clr_reg, cmd_clr_next;
    logic       e_reg, e_next;
    logic       s_reg, s_next;
    logic       r_reg, r_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       conflict_reg, conflict_next;
    logic       err_next;
    logic       drive_active;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        cmd_clr_next  = cmd_clr_reg;
        done_next     = 1'b0;
        conflict_next = 1'b0;
        err_next      = 1'b0;
        drive_active  = 1'b0;
        e_next        = 1'b0;
        s_next        = 1'b0;
        r_next        = 1'b0;
        busy_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (clr_req || set_req) begin
                    cmd_clr_next  = clr_req;
                    conflict_next = clr_req && set_req;
                    state_next    = SETUP;
                    cnt_next      = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt_reg == 8'd0) begin
                    state_next = PULSE;
                    cnt_next   = PULSE_LOAD;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            PULSE: begin
                if (cnt_reg == 8'd0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_reg == 8'd0) begin
                    cnt_next = 8'd0;
`ifdef SR_PULSE_DRIVER_VERIFY_EN
                    state_next = CHECK;
`else
                    state_next = IDLE;
                    done_next  = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
`ifdef SR_PULSE_DRIVER_VERIFY_EN
            CHECK: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
                done_next  = 1'b1;
                // The latch must now sit in the state the command asked for.
                err_next   = cmd_clr_reg ? (q || !qnot) : (!q || qnot);
            end
`endif
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase

        // Registered outputs are decoded from the state being entered.
        drive_active = (state_next == SETUP) || (state_next == PULSE) || (state_next == HOLD);
        e_next       = (state_next == PULSE);
        s_next       = drive_active && !cmd_clr_next;
        r_next       = drive_active && cmd_clr_next;
        busy_next    = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            cmd_clr_reg  <= 1'b0;
            e_reg        <= 1'b0;
            s_reg        <= 1'b0;
            r_reg        <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            conflict_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cmd_clr_reg  <= cmd_clr_next;
            e_reg        <= e_next;
            s_reg        <= s_next;
            r_reg        <= r_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            conflict_reg <= conflict_next;
        end
    end

`ifdef SR_PULSE_DRIVER_VERIFY_EN
    logic err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err = err_reg;
`else
    logic unused_feedback;

    assign unused_feedback = q ^ qnot ^ err_next;
    assign err             = 1'b0;
`endif

    assign e        = e_reg;
    assign s        = s_reg;
    assign r        = r_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign conflict = conflict_reg;

endmodule
